// File: rtl/cpu_params_pkg.sv
// rtl/cpu_params_pkg.sv - CPU width parameters shared by the cache/memory path
package cpu_params_pkg;

  localparam int PC_SZ  = 32;
  localparam int CL_LEN = 16;
  localparam int CL_SZ  = $clog2(CL_LEN);
  localparam int CLW    = CL_LEN * 8;

endpackage

// File: rtl/cpu_structs_pkg.sv
// rtl/cpu_structs_pkg.sv - shared request struct and arbiter state type
package cpu_structs_pkg;

  import cpu_params_pkg::*;

  // rw=1 read, rw=0 write; rw_addr is a cache-line address (byte offset dropped)
  typedef struct packed {
    logic                    rw;
    logic [PC_SZ-CL_SZ-1:0]  rw_addr;
    logic [CL_LEN*8-1:0]     wr_data;
  } ARB_Data;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RESP
  } ARB_STATE;

endpackage

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - arbitrates I$ and D$ line misses onto one memory port
module cache_arbiter
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           ic_req,
  input  ARB_Data        ic_req_data,
  output logic           ic_ack,
  output logic [CLW-1:0] ic_rd_data,
  input  logic           dc_req,
  input  ARB_Data        dc_req_data,
  output logic           dc_ack,
  output logic [CLW-1:0] dc_rd_data,
  output logic           sm_req,
  output ARB_Data        sm_req_data,
  input  logic           sm_ack,
  input  logic           sm_done,
  input  logic [CLW-1:0] sm_rd_data
);

  ARB_STATE state;
  logic     grant_dc;  // 1 = current transaction belongs to D$
  logic     last_dc;   // 1 = most recently completed grant went to D$
  logic     win_dc;

  // Pick the winner: a lone requester wins, ties go by FAIR (alternate or D$ first)
  always_comb begin
    win_dc = 1'b0;
    if (ic_req && dc_req) begin
      win_dc = FAIR ? !last_dc : 1'b1;
    end else begin
      win_dc = dc_req;
    end
  end

  // Transaction FSM; every output is a register written here
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= ARB_IDLE;
      grant_dc    <= 1'b0;
      last_dc     <= 1'b0;
      sm_req      <= 1'b0;
      sm_req_data <= '0;
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      ic_rd_data  <= '0;
      dc_rd_data  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (ic_req || dc_req) begin
            grant_dc    <= win_dc;
            sm_req_data <= win_dc ? dc_req_data : ic_req_data;
            sm_req      <= 1'b1;
            state       <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (sm_ack) begin
            sm_req <= 1'b0;
            if (sm_done) begin
              // memory accepted and finished in one cycle: skip the wait state
              if (grant_dc) begin
                dc_rd_data <= sm_rd_data;
                dc_ack     <= 1'b1;
              end else begin
                ic_rd_data <= sm_rd_data;
                ic_ack     <= 1'b1;
              end
              state <= ARB_RESP;
            end else begin
              state <= ARB_WAIT;
            end
          end
        end
        ARB_WAIT: begin
          if (sm_done) begin
            if (grant_dc) begin
              dc_rd_data <= sm_rd_data;
              dc_ack     <= 1'b1;
            end else begin
              ic_rd_data <= sm_rd_data;
              ic_ack     <= 1'b1;
            end
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          // ack is high for this one cycle; requests are re-examined from IDLE
          ic_ack  <= 1'b0;
          dc_ack  <= 1'b0;
          last_dc <= grant_dc;
          state   <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
module tb_cache_arbiter;
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;

  typedef struct {
    logic    is_dc;
    ARB_Data req;
  } exp_t;

  logic           clk;
  logic           reset_in;
  logic           sel;
  logic           ic_req_drv, dc_req_drv, sm_ack_drv, sm_done_drv;
  ARB_Data        ic_req_data, dc_req_data;
  logic [CLW-1:0] sm_rd_data;

  logic           ic_req_f, dc_req_f, sm_ack_f, sm_done_f;
  logic           ic_ack_f, dc_ack_f, sm_req_f;
  logic [CLW-1:0] ic_rd_data_f, dc_rd_data_f;
  ARB_Data        sm_req_data_f;
  logic           ic_req_p, dc_req_p, sm_ack_p, sm_done_p;
  logic           ic_ack_p, dc_ack_p, sm_req_p;
  logic [CLW-1:0] ic_rd_data_p, dc_rd_data_p;
  ARB_Data        sm_req_data_p;

  logic           m_sm_req, m_ic_ack, m_dc_ack;
  ARB_Data        m_sm_req_data;
  logic [CLW-1:0] m_ic_rd_data, m_dc_rd_data;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  assign ic_req_f  = ic_req_drv  & ~sel;
  assign dc_req_f  = dc_req_drv  & ~sel;
  assign sm_ack_f  = sm_ack_drv  & ~sel;
  assign sm_done_f = sm_done_drv & ~sel;
  assign ic_req_p  = ic_req_drv  & sel;
  assign dc_req_p  = dc_req_drv  & sel;
  assign sm_ack_p  = sm_ack_drv  & sel;
  assign sm_done_p = sm_done_drv & sel;

  assign m_sm_req      = sel ? sm_req_p      : sm_req_f;
  assign m_sm_req_data = sel ? sm_req_data_p : sm_req_data_f;
  assign m_ic_ack      = sel ? ic_ack_p      : ic_ack_f;
  assign m_dc_ack      = sel ? dc_ack_p      : dc_ack_f;
  assign m_ic_rd_data  = sel ? ic_rd_data_p  : ic_rd_data_f;
  assign m_dc_rd_data  = sel ? dc_rd_data_p  : dc_rd_data_f;

  cache_arbiter #(.FAIR(1'b1)) dut_f (
    .clk_in(clk), .reset_in(reset_in),
    .ic_req(ic_req_f), .ic_req_data(ic_req_data), .ic_ack(ic_ack_f), .ic_rd_data(ic_rd_data_f),
    .dc_req(dc_req_f), .dc_req_data(dc_req_data), .dc_ack(dc_ack_f), .dc_rd_data(dc_rd_data_f),
    .sm_req(sm_req_f), .sm_req_data(sm_req_data_f), .sm_ack(sm_ack_f), .sm_done(sm_done_f),
    .sm_rd_data(sm_rd_data)
  );

  cache_arbiter #(.FAIR(1'b0)) dut_p (
    .clk_in(clk), .reset_in(reset_in),
    .ic_req(ic_req_p), .ic_req_data(ic_req_data), .ic_ack(ic_ack_p), .ic_rd_data(ic_rd_data_p),
    .dc_req(dc_req_p), .dc_req_data(dc_req_data), .dc_ack(dc_ack_p), .dc_rd_data(dc_rd_data_p),
    .sm_req(sm_req_p), .sm_req_data(sm_req_data_p), .sm_ack(sm_ack_p), .sm_done(sm_done_p),
    .sm_rd_data(sm_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    tick();
  endtask

  // Act as system memory for one transaction and check it against the scoreboard head
  task automatic serve(input int exp_wait, input int ack_dly, input int done_dly,
                       input logic [CLW-1:0] data);
    int   n;
    exp_t e;
    n = 0;
    while (!m_sm_req && n < 20) begin
      tick();
      n++;
    end
    chk("sm_req_rise", 160'(m_sm_req), 160'(1));
    if (exp_wait >= 0) chk("req_latency", 160'(n), 160'(exp_wait));
    chk("sb_nonempty", 160'(sb.size() != 0), 160'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("sm_req_data", 160'(m_sm_req_data), 160'(e.req));
    sm_rd_data = data;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("hold_sm_req", 160'(m_sm_req), 160'(1));
      chk("hold_sm_data", 160'(m_sm_req_data), 160'(e.req));
    end
    sm_ack_drv  = 1'b1;
    sm_done_drv = (done_dly == 0);
    tick();
    sm_ack_drv  = 1'b0;
    sm_done_drv = 1'b0;
    chk("sm_req_clear", 160'(m_sm_req), 160'(0));
    if (done_dly > 0) begin
      for (int i = 0; i < done_dly - 1; i++) begin
        chk("early_ack", 160'(m_ic_ack | m_dc_ack), 160'(0));
        tick();
      end
      sm_done_drv = 1'b1;
      tick();
      sm_done_drv = 1'b0;
    end
    sm_rd_data = ~data;
    chk("ic_ack", 160'(m_ic_ack), 160'(!e.is_dc));
    chk("dc_ack", 160'(m_dc_ack), 160'(e.is_dc));
    if (e.req.rw) chk("rd_data", 160'(e.is_dc ? m_dc_rd_data : m_ic_rd_data), 160'(data));
    tick();
    chk("ack_one_cycle", 160'({m_ic_ack, m_dc_ack}), 160'(0));
  endtask

  initial begin
    ARB_Data d;
    reset_in    = 1'b1;
    sel         = 1'b0;
    ic_req_drv  = 1'b0;
    dc_req_drv  = 1'b0;
    sm_ack_drv  = 1'b0;
    sm_done_drv = 1'b0;
    ic_req_data = '0;
    dc_req_data = '0;
    sm_rd_data  = '0;
    tick();
    tick();

    // reset values
    chk("rst_sm_req", 160'(m_sm_req), 160'(0));
    chk("rst_sm_data", 160'(m_sm_req_data), 160'(0));
    chk("rst_acks", 160'({m_ic_ack, m_dc_ack}), 160'(0));
    chk("rst_rd", 160'(m_ic_rd_data | m_dc_rd_data), 160'(0));
    reset_in = 1'b0;
    tick();

    // I$ read: sm_req cycles 1-3, ack at 3, done at 6, ic_ack at 7
    d = '0; d.rw = 1'b1; d.rw_addr = 'h100;
    ic_req_data = d;
    ic_req_drv  = 1'b1;
    sb.push_back('{is_dc: 1'b0, req: d});
    serve(1, 2, 3, {CL_LEN{8'hA5}});
    ic_req_drv = 1'b0;
    chk("dc_idle", 160'(m_dc_ack), 160'(0));

    // same-cycle sm_ack and sm_done skip the wait state
    d = '0; d.rw = 1'b1; d.rw_addr = 'h2A4; d.wr_data = {CL_LEN{8'h11}};
    ic_req_data = d;
    ic_req_drv  = 1'b1;
    sb.push_back('{is_dc: 1'b0, req: d});
    serve(1, 0, 0, {CL_LEN{8'h3C}});
    ic_req_drv = 1'b0;

    // D$ write passes rw/addr/wr_data unchanged
    d = '0; d.rw = 1'b0; d.rw_addr = 'h3F;
    d.wr_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    dc_req_data = d;
    dc_req_drv  = 1'b1;
    sb.push_back('{is_dc: 1'b1, req: d});
    serve(1, 1, 2, {CL_LEN{8'h77}});
    dc_req_drv = 1'b0;

    // requester drops req mid-transaction; ack still delivered
    d = '0; d.rw = 1'b1; d.rw_addr = 'h555;
    ic_req_data = d;
    ic_req_drv  = 1'b1;
    sb.push_back('{is_dc: 1'b0, req: d});
    tick();
    ic_req_drv = 1'b0;
    serve(0, 1, 1, {CL_LEN{8'h5A}});

    // spurious sm_ack/sm_done in IDLE change nothing
    sm_ack_drv  = 1'b1;
    sm_done_drv = 1'b1;
    tick();
    sm_ack_drv  = 1'b0;
    sm_done_drv = 1'b0;
    chk("spur_sm_req", 160'(m_sm_req), 160'(0));
    chk("spur_acks", 160'({m_ic_ack, m_dc_ack}), 160'(0));
    tick();
    chk("spur_acks2", 160'({m_ic_ack, m_dc_ack}), 160'(0));
    d = '0; d.rw = 1'b1; d.rw_addr = 'h0C0;
    dc_req_data = d;
    dc_req_drv  = 1'b1;
    sb.push_back('{is_dc: 1'b1, req: d});
    serve(1, 0, 1, {CL_LEN{8'hE1}});
    dc_req_drv = 1'b0;

    // reset while waiting for memory abandons the transaction
    d = '0; d.rw = 1'b1; d.rw_addr = 'h777; d.wr_data = {CL_LEN{8'hFF}};
    ic_req_data = d;
    ic_req_drv  = 1'b1;
    tick();
    chk("pre_rst_req", 160'(m_sm_req), 160'(1));
    sm_ack_drv = 1'b1;
    tick();
    sm_ack_drv = 1'b0;
    #2;
    reset_in = 1'b1;
    #1;
    chk("arst_sm_data", 160'(m_sm_req_data), 160'(0));
    chk("arst_sm_req", 160'(m_sm_req), 160'(0));
    chk("arst_rd", 160'(m_ic_rd_data | m_dc_rd_data), 160'(0));
    chk("arst_acks", 160'({m_ic_ack, m_dc_ack}), 160'(0));
    ic_req_drv = 1'b0;
    tick();
    reset_in = 1'b0;
    tick();
    sm_done_drv = 1'b1;
    sm_rd_data  = {CL_LEN{8'h99}};
    tick();
    sm_done_drv = 1'b0;
    chk("stray_done_ack", 160'({m_ic_ack, m_dc_ack}), 160'(0));
    tick();
    chk("stray_done_ack2", 160'({m_ic_ack, m_dc_ack}), 160'(0));
    chk("stray_rd", 160'(m_ic_rd_data), 160'(0));

    // FAIR=1: simultaneous persistent requests alternate D,I,D,I
    do_reset();
    d = '0; d.rw = 1'b1; d.rw_addr = 'h010; ic_req_data = d;
    d = '0; d.rw = 1'b1; d.rw_addr = 'h020; dc_req_data = d;
    for (int k = 0; k < 4; k++) sb.push_back('{is_dc: (k % 2 == 0), req: (k % 2 == 0) ? dc_req_data : ic_req_data});
    ic_req_drv = 1'b1;
    dc_req_drv = 1'b1;
    for (int k = 0; k < 4; k++) serve(1, 0, 1, CLW'(k + 1));
    ic_req_drv = 1'b0;
    dc_req_drv = 1'b0;
    tick();

    // FAIR=0: D$ keeps winning until it drops
    sel = 1'b1;
    do_reset();
    sb.push_back('{is_dc: 1'b1, req: dc_req_data});
    sb.push_back('{is_dc: 1'b1, req: dc_req_data});
    sb.push_back('{is_dc: 1'b0, req: ic_req_data});
    ic_req_drv = 1'b1;
    dc_req_drv = 1'b1;
    serve(1, 1, 1, CLW'(16'hD001));
    serve(1, 0, 2, CLW'(16'hD002));
    dc_req_drv = 1'b0;
    serve(1, 0, 1, CLW'(16'h1003));
    ic_req_drv = 1'b0;
    tick();

    // random traffic: the two acks are never high together
    sel = 1'b0;
    for (int k = 0; k < 300; k++) begin
      ic_req_drv  = 1'($urandom_range(0, 1));
      dc_req_drv  = 1'($urandom_range(0, 1));
      sm_ack_drv  = 1'($urandom_range(0, 1));
      sm_done_drv = 1'($urandom_range(0, 1));
      sm_rd_data  = CLW'($urandom);
      tick();
      chk("ack_exclusive", 160'(m_ic_ack & m_dc_ack), 160'(0));
    end
    ic_req_drv  = 1'b0;
    dc_req_drv  = 1'b0;
    sm_ack_drv  = 1'b0;
    sm_done_drv = 1'b0;
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin between I$ and D$; 0 = fixed D$ priority.
REQ-002 Widths SHALL come from cpu_params_pkg: PC_SZ, CL_SZ, CL_LEN. CLW = CL_LEN*8 below.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk_in  input  1  sole clock; all state changes on rising edge.
REQ-005 reset_in  input  1  asynchronous, active-high reset.
REQ-006 ic_req  input  1  I$ miss request, level, held until ic_ack.
REQ-007 ic_req_data  input  ARB_Data  I$ request (rw, cache-line rw_addr, wr_data); stable while ic_req=1.
REQ-008 ic_ack  output  1  one-cycle completion pulse to I$.
REQ-009 ic_rd_data  output  CLW  read line for I$; valid only when ic_ack=1.
REQ-010 dc_req, dc_req_data, dc_ack, dc_rd_data: same as REQ-006..009, for D$.
REQ-011 sm_req  output  1  request to system memory, held until sm_ack.
REQ-012 sm_req_data  output  ARB_Data  registered copy of the granted request.
REQ-013 sm_ack  input  1  memory accepted sm_req this cycle.
REQ-014 sm_done  input  1  memory finished the accepted transaction (read or write).
REQ-015 sm_rd_data  input  CLW  read line; valid when sm_done=1.

Function
REQ-016 FSM states: ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP; one transaction outstanding at most.
REQ-017 ARB_IDLE, no req asserted: stay in ARB_IDLE.
REQ-018 ARB_IDLE, any req asserted: latch the winner's ARB_Data into sm_req_data, record the grant, set sm_req=1 next cycle, go to ARB_REQ. First sm_req is one cycle after req.
REQ-019 Arbitration with both requests asserted, FAIR=1: grant the requester not granted last.
REQ-020 Arbitration with both requests asserted, FAIR=0: grant D$.
REQ-021 Arbitration with a single request: grant that requester.
REQ-022 ARB_REQ: hold sm_req and sm_req_data constant until sm_ack.
REQ-023 ARB_REQ, sm_ack=1: clear sm_req next cycle and go to ARB_WAIT.
REQ-024 ARB_REQ, sm_ack=1 and sm_done=1 in the same cycle: capture sm_rd_data and go directly to ARB_RESP.
REQ-025 ARB_WAIT, sm_done=1: capture sm_rd_data into the granted requester's rd_data register and go to ARB_RESP.
REQ-026 ARB_RESP: assert the granted requester's ack for exactly one cycle, update the last-grant pointer, return to ARB_IDLE.
REQ-027 ARB_RESP: incoming req levels are ignored; re-arbitration happens in ARB_IDLE on the next cycle, so back-to-back requests see 1 idle cycle.
REQ-028 sm_done or sm_ack outside ARB_REQ/ARB_WAIT SHALL be ignored.
REQ-029 A requester dropping req mid-transaction SHALL NOT abort it; the transaction completes and ack is still pulsed.
REQ-030 For write transactions (rw=0), rd_data is don't-care but ack timing is unchanged.
REQ-031 ic_ack and dc_ack SHALL never be asserted together.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On reset_in=1, immediately and regardless of state: state=ARB_IDLE, sm_req=0, sm_req_data=0, ic_ack=dc_ack=0, ic_rd_data=dc_rd_data=0, last-grant=I$ (so D$ wins the first tie).
REQ-034 A transaction in flight at reset is abandoned with no ack; the memory side is reset by the same reset_in.

Structure
REQ-035 ARB_Data is taken from cpu_structs_pkg.
REQ-036 ARB_STATE enum {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP} SHALL be added to cpu_structs_pkg.
REQ-037 No sub-module is required; grant logic is inline combinational logic feeding the FSM.

Verification
REQ-038 ic_req=1, rw=1, addr='h100; sm_ack at cycle 3, sm_done at cycle 6 with data 'hA5.. -> sm_req high cycles 1-3; ic_ack pulse at cycle 7 with ic_rd_data='hA5..; dc_ack stays 0.
REQ-039 FAIR=1, ic_req and dc_req asserted together at cycle 0 after reset, each re-requesting after ack -> grants alternate D,I,D,I; with FAIR=0 -> D,D until dc_req drops.
REQ-040 sm_ack and sm_done in the same cycle as sm_req's first cycle -> ack pulses on the next cycle; ARB_WAIT is skipped.
REQ-041 dc write, rw=0, addr='h3F -> sm_req_data.rw=0 and wr_data passed unchanged; dc_ack pulses one cycle after sm_done.
REQ-042 reset_in pulsed while in ARB_WAIT -> all outputs are 0 asynchronously; a later stray sm_done produces no ack.
REQ-043 Spurious sm_done while in ARB_IDLE -> no ack and no state change; random stimulus checks that ic_ack and dc_ack are never both high.
